// File: rtl/pkg_global.sv
// -----------------------------------------------------------------------------
// pkg_global
// Shared definitions for the SPI transaction sequencer:
//   - bit positions of the fields in the 32-bit control word
//   - ctrl_word_t : packed view of the control word, LSB = send
//   - seq_state_t : sequencer FSM states
//   - decode_ctrl : builds a ctrl_word_t from a raw control word
// -----------------------------------------------------------------------------
package pkg_global;

  localparam int CTRL_SEND_BIT    = 0;
  localparam int CTRL_CS_CTRL_BIT = 1;
  localparam int CTRL_ALL_1S_BIT  = 2;
  localparam int CTRL_ALL_0S_BIT  = 3;
  localparam int CTRL_N_TX_LSB    = 4;
  localparam int CTRL_N_TX_MSB    = 12;
  localparam int CTRL_N_RX_LSB    = 16;
  localparam int CTRL_N_RX_MSB    = 25;

  // Field order is MSB first so the packed layout matches the register map.
  typedef struct packed {
    logic [5:0] rsvd_hi;   // [31:26]
    logic [9:0] n_rx_end;  // [25:16]
    logic [2:0] rsvd_mid;  // [15:13]
    logic [8:0] n_tx_end;  // [12:4]
    logic       all_0s;    // [3]
    logic       all_1s;    // [2]
    logic       cs_ctrl;   // [1]
    logic       send;      // [0]
  } ctrl_word_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    END   = 3'd4
  } seq_state_t;

  function automatic ctrl_word_t decode_ctrl(input logic [31:0] word);
    ctrl_word_t c;
    c          = '0;
    c.send     = word[CTRL_SEND_BIT];
    c.cs_ctrl  = word[CTRL_CS_CTRL_BIT];
    c.all_1s   = word[CTRL_ALL_1S_BIT];
    c.all_0s   = word[CTRL_ALL_0S_BIT];
    c.n_tx_end = word[CTRL_N_TX_MSB:CTRL_N_TX_LSB];
    c.n_rx_end = word[CTRL_N_RX_MSB:CTRL_N_RX_LSB];
    return c;
  endfunction

endpackage

// File: rtl/spi_seq_tx_mux.sv
// -----------------------------------------------------------------------------
// spi_seq_tx_mux
// Combinational source select for the byte handed to the SPI engine.
//   all_1s   in  1  force 8'hFF (wins over all_0s)
//   all_0s   in  1  force 8'h00
//   buf_data in  8  TX buffer read data
//   tx_byte  out 8  selected byte
// -----------------------------------------------------------------------------
module spi_seq_tx_mux (
  input  logic       all_1s,
  input  logic       all_0s,
  input  logic [7:0] buf_data,
  output logic [7:0] tx_byte
);

  // Per bit: all_1s forces a one; otherwise all_0s masks the buffer bit.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign tx_byte[gi] = all_1s | (~all_0s & buf_data[gi]);
    end
  endgenerate

endmodule

// File: rtl/spi_txn_sequencer.sv
// -----------------------------------------------------------------------------
// spi_txn_sequencer
// Runs one SPI burst described by the control word: fetches each byte from the
// TX buffer, hands it to the byte engine, writes the received byte to the RX
// buffer and reports the running count back to the control register.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   ctrl_i      control word (send, cs_ctrl, all_1s, all_0s, n_tx_end, n_rx_end)
//   proccess_o  one-cycle strobe at transaction end
//   we_rx_o / rx_count_o   running received-byte count write port
//   start_o / tx_byte_o    byte engine start and data
//   done_i / rx_byte_i     byte engine completion and received data
//   tx_addr_o / tx_data_i  TX buffer read port (1-cycle latency)
//   rx_addr_o / rx_we_o / rx_data_o  RX buffer write port
//   cs_o, busy_o, error_o
//
// Optional: define SPI_SEQ_TIMEOUT_EN to abort a byte that takes TIMEOUT
// cycles; otherwise error_o is tied low and WAIT has no limit.
// -----------------------------------------------------------------------------
module spi_txn_sequencer #(
  parameter int   ADDR_W    = 9,
  parameter logic CS_ACTIVE = 1'b0,
  parameter int   TIMEOUT   = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       ctrl_i,
  output logic              proccess_o,
  output logic              we_rx_o,
  output logic [9:0]        rx_count_o,
  output logic              start_o,
  output logic [7:0]        tx_byte_o,
  input  logic              done_i,
  input  logic [7:0]        rx_byte_i,
  output logic [ADDR_W-1:0] tx_addr_o,
  input  logic [7:0]        tx_data_i,
  output logic [ADDR_W-1:0] rx_addr_o,
  output logic              rx_we_o,
  output logic [7:0]        rx_data_o,
  output logic              cs_o,
  output logic              busy_o,
  output logic              error_o
);

  import pkg_global::*;

  seq_state_t        state_reg, state_next;
  ctrl_word_t        ctrl_reg, ctrl_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              cs_reg, cs_next;
  logic [9:0]        rx_count_reg, rx_count_next;
  logic              we_rx_reg, we_rx_next;
  // Set for the first IDLE cycle after END so a send bit the register has not
  // yet cleared cannot restart the burst back-to-back.
  logic              skip_reg, skip_next;
  logic              timed_out;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             error_reg, error_next;

  assign timed_out = error_reg;
  assign error_o   = error_reg;
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT;

  assign timed_out = 1'b0;
  assign error_o   = 1'b0;
`endif

  // n_rx_end and the reserved bits are carried in the latch but not acted on.
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl_reg.n_rx_end, ctrl_reg.rsvd_hi, ctrl_reg.rsvd_mid, ctrl_reg.send};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      ctrl_reg     <= '0;
      idx_reg      <= '0;
      cs_reg       <= ~CS_ACTIVE;
      rx_count_reg <= '0;
      we_rx_reg    <= 1'b0;
      skip_reg     <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      tmo_cnt_reg  <= '0;
      error_reg    <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      ctrl_reg     <= ctrl_next;
      idx_reg      <= idx_next;
      cs_reg       <= cs_next;
      rx_count_reg <= rx_count_next;
      we_rx_reg    <= we_rx_next;
      skip_reg     <= skip_next;
`ifdef SPI_SEQ_TIMEOUT_EN
      tmo_cnt_reg  <= tmo_cnt_next;
      error_reg    <= error_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    ctrl_next     = ctrl_reg;
    idx_next      = idx_reg;
    cs_next       = cs_reg;
    rx_count_next = rx_count_reg;
    we_rx_next    = 1'b0;
    skip_next     = 1'b0;
    start_o       = 1'b0;
    proccess_o    = 1'b0;
    rx_we_o       = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
    tmo_cnt_next  = '0;
    error_next    = error_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (ctrl_i[CTRL_SEND_BIT] && !skip_reg) begin
          ctrl_next  = decode_ctrl(ctrl_i);
          idx_next   = '0;
          cs_next    = CS_ACTIVE;
          state_next = FETCH;
`ifdef SPI_SEQ_TIMEOUT_EN
          error_next = 1'b0;
`endif
        end
      end

      // Address is on tx_addr_o this cycle; data arrives in START.
      FETCH: state_next = START;

      START: begin
        start_o    = 1'b1;
        state_next = WAIT;
      end

      WAIT: begin
`ifdef SPI_SEQ_TIMEOUT_EN
        tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
`endif
        if (done_i) begin
          rx_we_o       = 1'b1;
          we_rx_next    = 1'b1;
          rx_count_next = 10'(idx_reg) + 10'd1;
          if (idx_reg == ADDR_W'(ctrl_reg.n_tx_end)) begin
            state_next = END;
          end else begin
            idx_next   = idx_reg + ADDR_W'(1);
            state_next = FETCH;
          end
        end
`ifdef SPI_SEQ_TIMEOUT_EN
        else if (tmo_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
          error_next = 1'b1;
          state_next = END;
        end
`endif
      end

      END: begin
        proccess_o = 1'b1;
        skip_next  = 1'b1;
        // A timed-out burst always releases chip select.
        cs_next    = (ctrl_reg.cs_ctrl && !timed_out) ? CS_ACTIVE : ~CS_ACTIVE;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  spi_seq_tx_mux u_tx_mux (
    .all_1s   (ctrl_reg.all_1s),
    .all_0s   (ctrl_reg.all_0s),
    .buf_data (tx_data_i),
    .tx_byte  (tx_byte_o)
  );

  assign tx_addr_o  = idx_reg;
  assign rx_addr_o  = idx_reg;
  assign rx_data_o  = rx_byte_i;
  assign cs_o       = cs_reg;
  assign busy_o     = (state_reg != IDLE);
  assign we_rx_o    = we_rx_reg;
  assign rx_count_o = rx_count_reg;

endmodule

// File: doc/spi_txn_sequencer.md
Name: spi_txn_sequencer

Overview:
- Sequences one SPI transaction from the control-register word: sends a multi-byte burst through the byte-level SPI engine and moves data between the TX and RX buffers.
- Reports the running received-byte count back to the control register through its rx write port.
- Raises the process strobe on completion so the register clears its send bit.
- Sits between the control register, the TX/RX buffers and the SPI byte engine.

Parameters:
ADDR_W, 9, buffer address width; maximum burst is 2**ADDR_W bytes
CS_ACTIVE, 1'b0, active level of cs_o
TIMEOUT, 1024, cycles allowed for one byte before abort (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
ctrl_i  in  32  control word: [0] send, [1] cs_ctrl, [2] all_1s, [3] all_0s, [12:4] n_tx_end, [25:16] n_rx_end (read-only here)
proccess_o  out  1  one-cycle strobe on transaction end
we_rx_o  out  1  one-cycle strobe; rx_count_o is valid
rx_count_o  out  10  bytes received so far
start_o  out  1  one-cycle start to the byte engine
tx_byte_o  out  8  byte to transmit, valid while start_o is high
done_i  in  1  byte engine finished; rx_byte_i is valid
rx_byte_i  in  8  received byte
tx_addr_o  out  ADDR_W  TX buffer read address (buffer has 1-cycle read latency)
tx_data_i  in  8  TX buffer read data
rx_addr_o  out  ADDR_W  RX buffer write address
rx_we_o  out  1  RX buffer write enable
rx_data_o  out  8  RX buffer write data
cs_o  out  1  chip select
busy_o  out  1  high in every state except IDLE
error_o  out  1  timeout flag (tied 0 when the optional feature is compiled out)

Behaviour:
- Reset (asynchronous): FSM in IDLE; all strobes 0; counters 0; cs_o = ~CS_ACTIVE; rx_count_o = 0; error_o = 0.
- Reset asserted mid-transaction aborts immediately: no proccess_o, and cs_o is deasserted in the same cycle.
- IDLE: on ctrl_i[0] = 1, latch the control word. Number of bytes N = n_tx_end + 1 (range 1..512). Then idx = 0, cs_o = CS_ACTIVE, go to FETCH.
- FETCH: drive tx_addr_o = idx, then wait one cycle for tx_data_i; go to START.
- START: drive start_o = 1 for one cycle, go to WAIT. tx_byte_o source:
  - all_1s set: 8'hFF (all_1s has priority if both bits are set)
  - else all_0s set: 8'h00
  - else: tx_data_i
- WAIT: hold until done_i. On done_i:
  - in the same cycle, rx_we_o = 1, rx_addr_o = idx, rx_data_o = rx_byte_i;
  - next cycle, we_rx_o = 1 with rx_count_o = idx + 1.
  - If idx == N-1, go to END; else idx++, go to FETCH.
- done_i outside WAIT is ignored.
- END:
  - proccess_o = 1 for one cycle.
  - cs_o returns to ~CS_ACTIVE unless the latched cs_ctrl = 1, in which case cs_o is held active until the next transaction's END with cs_ctrl = 0.
  - Go to IDLE.
- ctrl_i changes after the latch have no effect until the next IDLE.
- IDLE re-arms only when the send bit is seen again. If send is still 1 on the cycle after END (register not yet cleared), wait one cycle: no back-to-back restart from a stale bit.
- Per-byte latency: FETCH (1) + START (1) + engine time + 1 cycle write-back.
- rx_count_o wraps at 10 bits. It cannot exceed 512 by construction.

Optional Feature:
- Macro: SPI_SEQ_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT. If done_i is absent for TIMEOUT cycles, the sequencer:
  - sets error_o (sticky until the next accepted send),
  - deasserts cs_o regardless of cs_ctrl,
  - pulses proccess_o,
  - returns to IDLE; rx_count_o keeps the partial count.
- Undefined: no counter is built, error_o is tied to 0, and WAIT waits indefinitely.

Decomposition:
- Shared package pkg_global gets:
  - a packed struct for the control-word fields (send, cs_ctrl, all_1s, all_0s, n_tx_end, n_rx_end);
  - the FSM state enum (IDLE, FETCH, START, WAIT, END);
  - bit-position constants for the fields.
- One natural sub-module: spi_seq_tx_mux, the combinational source select for tx_byte_o (all_1s / all_0s / buffer).
- The FSM and counters stay in the top module.

Test Plan:
- ctrl_i = 32'h0000_0001 (N = 1, buffer source), tx_data[0] = 8'hA5, engine loops back -> one start_o, tx_byte_o = A5; rx[0] = A5; we_rx_o with count 1; proccess_o; cs_o back high.
- n_tx_end = 3, all_1s = 1 -> four start_o pulses, each with tx_byte_o = FF; rx_count_o steps 1, 2, 3, 4; rx_addr_o 0..3.
- all_1s = all_0s = 1, N = 2 -> both bytes FF (priority check).
- cs_ctrl = 1, N = 1 -> cs_o stays low after END. Next send with cs_ctrl = 0 -> cs_o high after that END.
- rst_i asserted in WAIT after byte 2 of 4 -> cs_o high and busy_o 0 immediately; no proccess_o; rx_count_o = 0.
- With SPI_SEQ_TIMEOUT_EN and TIMEOUT = 16, done_i withheld -> after 16 cycles error_o = 1, proccess_o pulses, cs_o high, rx_count_o holds the prior count.
